// File: rtl/nq_pkg.sv
// Shared sequencer definitions: FSM states, fault codes and the nop opcode.
package nq_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StExec,
        StMem,
        StCommit,
        StFault
    } seq_state_e;

    localparam logic [1:0] FaultNone    = 2'b00;
    localparam logic [1:0] FaultTimeout = 2'b01;
    localparam logic [1:0] FaultAlign   = 2'b10;
    localparam logic [1:0] FaultMulti   = 2'b11;

    localparam logic [15:0] NopInstr = 16'hF000;

    // Number of memory-operation bits raised by the decoder.
    function automatic logic [2:0] mem_op_count(logic [3:0] ops);
        return {2'b00, ops[0]} + {2'b00, ops[1]} + {2'b00, ops[2]} + {2'b00, ops[3]};
    endfunction

endpackage

// File: rtl/mem_timeout.sv
// Counts unacknowledged request cycles and flags the cycle in which the limit is reached.
module mem_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int unsigned W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (count) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // This cycle is the TIMEOUT-th unacknowledged one.
    assign expired = count && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetch, decode-check, optional data access, commit.
module cpu_sequencer
    import nq_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_wdata,
    input  logic [3:0]  dec_mem,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic        mem_word,
    output logic [15:0] mem_wdata,
    output logic [15:0] instr_q,
    output logic [15:0] mem_data_q,
    output logic        pc_inc,
    output logic        commit,
    output logic        fault,
    output logic [1:0]  fault_code
);

    seq_state_e state_q, state_d;
    logic       pc_valid_q;
    logic       instr_load, data_load, fault_set;
    logic [1:0] fault_code_d;
    logic       req_phase, tmo_clear, tmo_count, tmo_expired;
    logic       is_word, is_write, is_read;

    assign is_word  = dec_mem[2] | dec_mem[0];
    assign is_write = dec_mem[1] | dec_mem[0];
    assign is_read  = dec_mem[3] | dec_mem[2];

    // Reset drops the request in the same cycle so an in-flight access is abandoned.
    assign req_phase = ((state_q == StFetch) || (state_q == StMem)) && !reset;
    assign tmo_count = req_phase && !mem_ack;
    assign tmo_clear = (state_d != state_q) && ((state_d == StFetch) || (state_d == StMem));
    assign fault     = (state_q == StFault);

    mem_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_mem_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmo_clear),
        .count  (tmo_count),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d      = state_q;
        mem_req      = req_phase;
        mem_addr     = 16'h0000;
        mem_we       = 1'b0;
        mem_word     = 1'b0;
        mem_wdata    = 16'h0000;
        pc_inc       = 1'b0;
        commit       = 1'b0;
        instr_load   = 1'b0;
        data_load    = 1'b0;
        fault_set    = 1'b0;
        fault_code_d = fault_code;

        unique case (state_q)
            StFetch: begin
                mem_word = 1'b1;
                mem_addr = pc_valid_q ? pc : RESET_PC;
                if (mem_ack) begin
                    instr_load = 1'b1;
                    pc_inc     = 1'b1;
                    state_d    = StExec;
                end else if (tmo_expired) begin
                    fault_set    = 1'b1;
                    fault_code_d = FaultTimeout;
                    state_d      = StFault;
                end
            end
            StExec: begin
                if (mem_op_count(dec_mem) > 3'd1) begin
                    fault_set    = 1'b1;
                    fault_code_d = FaultMulti;
                    state_d      = StFault;
                end else if (is_word && data_addr[0]) begin
                    fault_set    = 1'b1;
                    fault_code_d = FaultAlign;
                    state_d      = StFault;
                end else if (dec_mem != 4'b0000) begin
                    state_d = StMem;
                end else begin
                    state_d = StCommit;
                end
            end
            StMem: begin
                mem_addr  = data_addr;
                mem_we    = is_write;
                mem_word  = is_word;
                mem_wdata = is_word ? data_wdata : {8'h00, data_wdata[7:0]};
                if (mem_ack) begin
                    data_load = is_read;
                    state_d   = StCommit;
                end else if (tmo_expired) begin
                    fault_set    = 1'b1;
                    fault_code_d = FaultTimeout;
                    state_d      = StFault;
                end
            end
            StCommit: begin
                commit  = 1'b1;
                state_d = StFetch;
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StFault;
            end
        endcase

        if (reset) begin
            pc_inc = 1'b0;
            commit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            instr_q    <= NopInstr;
            mem_data_q <= 16'h0000;
            fault_code <= FaultNone;
            pc_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (instr_load) begin
                instr_q <= mem_rdata;
            end
            if (data_load) begin
                mem_data_q <= is_word ? mem_rdata : {8'h00, mem_rdata[7:0]};
            end
            if (pc_inc) begin
                pc_valid_q <= 1'b1;
            end
            if (fault_set) begin
                fault_code <= fault_code_d;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer against an instruction-level reference model.
module tb_cpu_sequencer;

    localparam int unsigned TO  = 4;
    localparam logic [15:0] RPC = 16'h0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc = RPC, data_addr = 16'h0, data_wdata = 16'h0, mem_rdata = 16'h0;
    logic [3:0]  dec_mem = 4'h0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, mem_word, pc_inc, commit, fault;
    logic [15:0] mem_addr, mem_wdata, instr_q, mem_data_q;
    logic [1:0]  fault_code;

    cpu_sequencer #(
        .TIMEOUT (TO),
        .RESET_PC(RPC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .data_addr (data_addr),
        .data_wdata(data_wdata),
        .dec_mem   (dec_mem),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_word  (mem_word),
        .mem_wdata (mem_wdata),
        .instr_q   (instr_q),
        .mem_data_q(mem_data_q),
        .pc_inc    (pc_inc),
        .commit    (commit),
        .fault     (fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Expected outputs for the current cycle
    logic        e_chk = 1'b0, e_regs = 1'b0;
    logic        e_req, e_pcinc, e_commit, e_fault, e_we, e_word;
    logic [1:0]  e_code;
    logic [15:0] e_addr, e_instr, e_data, e_wdata, e_wmask;

    // Reference model state
    logic [15:0] m_pc, m_instr, m_data;
    logic [1:0]  seen_code;
    int          cyc = 0, n_commit = 0, last_pcinc_cyc = 0, last_commit_cyc = 0;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (pc_inc === 1'b1) last_pcinc_cyc = cyc;
        if (commit === 1'b1) begin
            n_commit++;
            last_commit_cyc = cyc;
        end
        if (e_chk) begin
            cmp("mem_req", 16'(mem_req), 16'(e_req));
            cmp("pc_inc", 16'(pc_inc), 16'(e_pcinc));
            cmp("commit", 16'(commit), 16'(e_commit));
            if (e_regs) begin
                cmp("fault", 16'(fault), 16'(e_fault));
                cmp("fault_code", 16'(fault_code), 16'(e_code));
                cmp("instr_q", instr_q, e_instr);
                cmp("mem_data_q", mem_data_q, e_data);
            end
            if (e_req) begin
                cmp("mem_addr", mem_addr, e_addr);
                cmp("mem_we", 16'(mem_we), 16'(e_we));
                cmp("mem_word", 16'(mem_word), 16'(e_word));
            end
            if (e_wmask != 16'h0) cmp("mem_wdata", mem_wdata & e_wmask, e_wdata & e_wmask);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input logic regs);
        e_chk = 1'b1; e_regs = regs; e_req = 1'b0; e_pcinc = 1'b0; e_commit = 1'b0;
        e_wmask = 16'h0; e_fault = 1'b0; e_code = 2'b00; e_instr = m_instr; e_data = m_data;
    endtask

    task automatic model_reset();
        m_instr = 16'hF000; m_data = 16'h0000; m_pc = RPC; pc = RPC;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            reset = 1'b1;
            mem_ack = 1'($urandom);
            expect_idle(1'b0);
            step();
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic enter_fault(input logic [1:0] code);
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'($urandom); dec_mem = 4'($urandom); data_addr = 16'($urandom);
            expect_idle(1'b1);
            e_fault = 1'b1; e_code = code;
            step();
            if (i == 0) seen_code = fault_code;
        end
        do_reset(1 + int'($urandom_range(0, 1)));
    endtask

    // One instruction: fw/mw are ack wait counts, rst_at is the MEM wait cycle carrying a reset.
    task automatic run_instr(input logic [15:0] ins, input logic [3:0] dm,
                             input logic [15:0] daddr, input logic [15:0] wd,
                             input logic [15:0] rd, input int fw, input int mw,
                             input int rst_at);
        logic ack, wr, wrd;
        for (int w = 0; ; w++) begin
            pc = m_pc; dec_mem = 4'($urandom);
            ack = (w == fw);
            mem_ack = ack;
            mem_rdata = ack ? ins : 16'($urandom);
            expect_idle(1'b1);
            e_req = 1'b1; e_addr = m_pc; e_we = 1'b0; e_word = 1'b1; e_pcinc = ack;
            step();
            if (ack) begin
                m_instr = ins; m_pc = m_pc + 16'd2;
                break;
            end
            if (w == int'(TO) - 1) begin
                enter_fault(2'b01);
                return;
            end
        end
        pc = m_pc; dec_mem = dm; data_addr = daddr; data_wdata = wd;
        mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
        expect_idle(1'b1);
        step();
        if ($countones(dm) > 1) begin
            enter_fault(2'b11);
            return;
        end
        wr  = dm[1] | dm[0];
        wrd = dm[2] | dm[0];
        if (wrd && daddr[0]) begin
            enter_fault(2'b10);
            return;
        end
        if (dm != 4'b0000) begin
            for (int w = 0; ; w++) begin
                if (w == rst_at) begin
                    reset = 1'b1; mem_ack = 1'b1;
                    expect_idle(1'b0);
                    step();
                    reset = 1'b0;
                    model_reset();
                    return;
                end
                ack = (w == mw);
                mem_ack = ack;
                mem_rdata = ack ? rd : 16'($urandom);
                expect_idle(1'b1);
                e_req = 1'b1; e_addr = daddr; e_we = wr; e_word = wrd; e_wdata = wd;
                e_wmask = !wr ? 16'h0000 : (wrd ? 16'hFFFF : 16'h00FF);
                step();
                if (ack) begin
                    if (!wr) m_data = wrd ? rd : {8'h00, rd[7:0]};
                    break;
                end
                if (w == int'(TO) - 1) begin
                    enter_fault(2'b01);
                    return;
                end
            end
        end
        mem_ack = 1'($urandom);
        expect_idle(1'b1);
        e_commit = 1'b1;
        step();
    endtask

    initial begin
        int start, nc;
        logic [3:0] dm;
        logic [15:0] da;
        int fw, mw, ra, r;
        logic [3:0] multi [7] = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC, 4'hF};

        model_reset();
        step();
        do_reset(2);
        cmp("reset_instr_q", instr_q, 16'hF000);
        cmp("reset_mem_data_q", mem_data_q, 16'h0000);
        cmp("reset_fault_code", 16'(fault_code), 16'h0000);

        // Zero-wait ALU op: pc_inc in cycle 1, commit in cycle 3, fetch again in cycle 4
        start = cyc;
        run_instr(16'h0224, 4'b0000, 16'h0, 16'h0, 16'h0, 0, 0, -1);
        cmp("alu_instr_q", instr_q, 16'h0224);
        cmp("alu_pc_inc_cycle", 16'(last_pcinc_cyc - start), 16'd1);
        cmp("alu_commit_cycle", 16'(last_commit_cyc - start), 16'd3);
        cmp("alu_next_fetch", 16'(mem_req), 16'd1);

        // Word load with two wait cycles
        nc = n_commit;
        run_instr(16'h1111, 4'b0100, 16'h0010, 16'h0, 16'hBEEF, 0, 2, -1);
        cmp("word_load_data", mem_data_q, 16'hBEEF);
        cmp("word_load_commits", 16'(n_commit - nc), 16'd1);

        run_instr(16'h2222, 4'b1000, 16'h0021, 16'h0, 16'h12AB, 1, 0, -1);
        cmp("byte_load_data", mem_data_q, 16'h00AB);
        run_instr(16'h3333, 4'b0010, 16'h0023, 16'h3456, 16'h0, 0, 1, -1);

        run_instr(16'h4444, 4'b0001, 16'h0011, 16'hAAAA, 16'h0, 0, 0, -1);
        cmp("misaligned_code", 16'(seen_code), 16'h0002);
        run_instr(16'h5555, 4'b0000, 16'h0, 16'h0, 16'h0, 100, 0, -1);
        cmp("fetch_timeout_code", 16'(seen_code), 16'h0001);
        run_instr(16'h6666, 4'b0101, 16'h0040, 16'h0, 16'h0, 0, 0, -1);
        cmp("multi_op_code", 16'(seen_code), 16'h0003);
        run_instr(16'h7777, 4'b0100, 16'h0040, 16'h0, 16'h0, 0, 100, -1);
        cmp("mem_timeout_code", 16'(seen_code), 16'h0001);

        // Reset during a MEM wait, then the next fetch starts from the reset PC
        run_instr(16'h8888, 4'b0100, 16'h0050, 16'h0, 16'h9999, 0, 3, 1);
        run_instr(16'h9ABC, 4'b0000, 16'h0, 16'h0, 16'h0, 0, 0, -1);
        cmp("after_reset_instr", instr_q, 16'h9ABC);

        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)       dm = 4'b0000;
            else if (r < 8)  dm = 4'b0001 << $urandom_range(0, 3);
            else if (r == 8) dm = multi[$urandom_range(0, 6)];
            else             dm = 4'($urandom);
            da = 16'($urandom);
            if ($urandom_range(0, 3) != 0) da[0] = 1'b0;
            fw = ($urandom_range(0, 19) == 0) ? 10 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 19) == 0) ? 10 : int'($urandom_range(0, 3));
            ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_instr(16'($urandom), dm, da, 16'($urandom), 16'($urandom), fw, mw, ra);
        end

        e_chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
